// File: rtl/display_pkg.sv
// Shared character type, state encoding and constants for the scrolling display.
package display_pkg;

    localparam int CHAR_WIDTH = 8;
    localparam logic [CHAR_WIDTH-1:0] ASCII_SPACE = 8'h20;

    typedef enum logic [1:0] {IDLE, LOAD, SCROLL, PAUSED} scroll_state_t;

    typedef logic [CHAR_WIDTH-1:0] char_t;

endpackage

// File: rtl/tick_prescaler.sv
// Divides clk down to one scroll tick per (TICK_DIV >> speed) cycles.
// The count can be cleared (restart) or frozen (pause) by the sequencer.
module tick_prescaler #(
    parameter int TICK_DIV = 25_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clear,
    input  logic       hold,
    input  logic [1:0] speed,
    output logic       tick
);

    localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] terminal;

    // Terminal count for the selected speed, clamped so tiny dividers never go negative.
    always_comb begin
        terminal = '0;
        if ((TICK_DIV >> speed) > 1)
            terminal = CNT_W'((TICK_DIV >> speed) - 1);
    end

    // A count at or past the terminal fires at once, so a speed increase never overshoots.
    assign tick = !clear && !hold && (count >= terminal);

    // Step counter: cleared on reset or restart, frozen on hold, wraps on the terminal count.
    always_ff @(posedge clk) begin
        if (rst || clear)
            count <= '0;
        else if (!hold)
            count <= (count >= terminal) ? '0 : count + 1'b1;
    end

endmodule

// File: rtl/scroll_controller.sv
// Sequencer for the six-digit scrolling message display: loadable message buffer,
// IDLE/LOAD/SCROLL/PAUSED control and the registered character window.
module scroll_controller #(
    parameter int MAX_LEN      = 32,
    parameter int CHAR_WIDTH   = 8,
    parameter int NUM_DISPLAYS = 6,
    parameter int TICK_DIV     = 25_000_000
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   wr_valid,
    input  logic [CHAR_WIDTH-1:0]                  wr_data,
    input  logic                                   wr_last,
    output logic                                   wr_ready,
    input  logic                                   start,
    input  logic                                   stop,
    input  logic                                   pause,
    input  logic                                   scroll_dir,
    input  logic [1:0]                             speed,
    output logic [$clog2(MAX_LEN+1)-1:0]           msg_len,
    output logic                                   overflow,
    output logic [$clog2(MAX_LEN)-1:0]             scroll_index,
    output logic                                   step,
    output logic                                   busy,
    output logic [NUM_DISPLAYS-1:0][CHAR_WIDTH-1:0] display_chars
);

    import display_pkg::*;

    localparam int LEN_W = $clog2(MAX_LEN + 1);
    localparam int IDX_W = $clog2(MAX_LEN);
    localparam logic [LEN_W-1:0] MAX_LEN_L = LEN_W'(MAX_LEN);
    localparam logic [NUM_DISPLAYS-1:0][CHAR_WIDTH-1:0] ALL_SPACES =
        {NUM_DISPLAYS{CHAR_WIDTH'(ASCII_SPACE)}};

    scroll_state_t state;
    scroll_state_t state_next;

    logic [CHAR_WIDTH-1:0] buffer [MAX_LEN];
    logic [LEN_W-1:0]      wcount;
    logic [LEN_W-1:0]      wcount_inc;
    logic                  accept;
    logic                  buf_we;
    logic [IDX_W-1:0]      buf_addr;
    logic                  run_clear;
    logic                  run_hold;
    logic                  tick;
    logic [IDX_W-1:0]      index_next;
    logic [LEN_W:0]        pos;
    logic [NUM_DISPLAYS-1:0][CHAR_WIDTH-1:0] window;

    assign busy      = (state == SCROLL) || (state == PAUSED);
    assign wr_ready  = (state == IDLE) || (state == LOAD);
    assign accept    = wr_valid && wr_ready;
    assign run_clear = !busy || start || stop;
    assign run_hold  = (state == PAUSED) || pause;

    tick_prescaler #(
        .TICK_DIV (TICK_DIV)
    ) u_prescaler (
        .clk   (clk),
        .rst   (rst),
        .clear (run_clear),
        .hold  (run_hold),
        .speed (speed),
        .tick  (tick)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_next;
    end

    // Next-state logic; in the running states stop beats start, which beats pause.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept)
                    state_next = wr_last ? IDLE : LOAD;
                else if (start && msg_len != '0)
                    state_next = SCROLL;
            end
            LOAD: begin
                if (stop)
                    state_next = IDLE;
                else if (accept && wr_last)
                    state_next = IDLE;
            end
            SCROLL, PAUSED: begin
                if (stop)
                    state_next = IDLE;
                else if (start)
                    state_next = SCROLL;
                else if (pause)
                    state_next = PAUSED;
                else
                    state_next = SCROLL;
            end
            default: state_next = IDLE;
        endcase
    end

    // Buffer write port: first byte always lands at 0, later bytes until the buffer is full.
    always_comb begin
        buf_we     = 1'b0;
        buf_addr   = '0;
        wcount_inc = wcount;
        if (accept && state == IDLE) begin
            buf_we = 1'b1;
        end else if (accept && state == LOAD && !stop && wcount < MAX_LEN_L) begin
            buf_we     = 1'b1;
            buf_addr   = IDX_W'(wcount);
            wcount_inc = wcount + 1'b1;
        end
    end

    // Next window start, wrapping at either end of the stored message.
    always_comb begin
        index_next = scroll_index;
        if (!scroll_dir)
            index_next = ({1'b0, scroll_index} == msg_len - 1'b1) ? '0 : scroll_index + 1'b1;
        else
            index_next = (scroll_index == '0) ? IDX_W'(msg_len - 1'b1) : scroll_index - 1'b1;
    end

    // Window characters; repeated compare-subtract handles messages shorter than the display.
    always_comb begin
        window = '0;
        pos    = '0;
        for (int i = 0; i < NUM_DISPLAYS; i++) begin
            pos = (LEN_W+1)'(scroll_index) + (LEN_W+1)'(i);
            for (int k = 0; k < NUM_DISPLAYS; k++) begin
                if (msg_len != '0 && pos >= {1'b0, msg_len})
                    pos = pos - {1'b0, msg_len};
            end
            window[i] = buffer[pos[IDX_W-1:0]];
        end
    end

    // Message storage has no reset; contents are only meaningful up to msg_len.
    always_ff @(posedge clk) begin
        if (!rst && buf_we)
            buffer[buf_addr] <= wr_data;
    end

    // Load bookkeeping, scroll index, step pulse and the registered display window.
    always_ff @(posedge clk) begin
        if (rst) begin
            msg_len       <= '0;
            overflow      <= 1'b0;
            scroll_index  <= '0;
            step          <= 1'b0;
            wcount        <= '0;
            display_chars <= ALL_SPACES;
        end else begin
            step          <= tick;
            display_chars <= busy ? window : ALL_SPACES;
            case (state)
                IDLE: begin
                    if (accept) begin
                        wcount   <= LEN_W'(1);
                        overflow <= 1'b0;
                        if (wr_last)
                            msg_len <= LEN_W'(1);
                    end else if (start && msg_len != '0) begin
                        scroll_index <= '0;
                    end
                end
                LOAD: begin
                    if (!stop && accept) begin
                        wcount <= wcount_inc;
                        if (wcount == MAX_LEN_L)
                            overflow <= 1'b1;
                        if (wr_last)
                            msg_len <= wcount_inc;
                    end
                end
                default: begin
                    if (stop || start)
                        scroll_index <= '0;
                    else if (tick)
                        scroll_index <= index_next;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_scroll_controller.sv
// Self-checking bench for scroll_controller: directed scenarios plus a random phase,
// all checked every cycle against a behavioural model of the message scroller.
module tb_scroll_controller;

    import display_pkg::*;

    localparam int MAX_LEN      = 32;
    localparam int NUM_DISPLAYS = 6;
    localparam int TICK_DIV     = 16;
    localparam int LEN_W        = $clog2(MAX_LEN + 1);
    localparam int IDX_W        = $clog2(MAX_LEN);
    localparam int WIN_W        = CHAR_WIDTH * NUM_DISPLAYS;

    localparam int MODE_IDLE = 0;
    localparam int MODE_LOAD = 1;
    localparam int MODE_RUN  = 2;
    localparam int MODE_HALT = 3;

    logic       clk = 1'b0;
    logic       rst;
    logic       wr_valid;
    char_t      wr_data;
    logic       wr_last;
    logic       wr_ready;
    logic       start;
    logic       stop;
    logic       pause;
    logic       scroll_dir;
    logic [1:0] speed;
    logic [LEN_W-1:0] msg_len;
    logic       overflow;
    logic [IDX_W-1:0] scroll_index;
    logic       step;
    logic       busy;
    logic [NUM_DISPLAYS-1:0][CHAR_WIDTH-1:0] display_chars;

    scroll_controller #(
        .MAX_LEN      (MAX_LEN),
        .CHAR_WIDTH   (CHAR_WIDTH),
        .NUM_DISPLAYS (NUM_DISPLAYS),
        .TICK_DIV     (TICK_DIV)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .wr_valid      (wr_valid),
        .wr_data       (wr_data),
        .wr_last       (wr_last),
        .wr_ready      (wr_ready),
        .start         (start),
        .stop          (stop),
        .pause         (pause),
        .scroll_dir    (scroll_dir),
        .speed         (speed),
        .msg_len       (msg_len),
        .overflow      (overflow),
        .scroll_index  (scroll_index),
        .step          (step),
        .busy          (busy),
        .display_chars (display_chars)
    );

    always #5 clk = ~clk;

    // Behavioural model of the scroller.
    char_t          m_buf [MAX_LEN];
    int             m_mode;
    int             m_len;
    int             m_wcount;
    int             m_idx;
    int             m_pc;
    bit             m_over;
    bit             m_step;
    logic [WIN_W-1:0] m_disp;

    int vectors = 0;
    int fails   = 0;
    char_t txq[$];

    function automatic logic [WIN_W-1:0] textWindow(input string s);
        logic [WIN_W-1:0] r;
        r = '0;
        for (int i = 0; i < NUM_DISPLAYS; i++)
            r[CHAR_WIDTH*i +: CHAR_WIDTH] = s[i];
        return r;
    endfunction

    function automatic logic [WIN_W-1:0] modelWindow();
        logic [WIN_W-1:0] r;
        r = textWindow("      ");
        if (m_len > 0)
            for (int i = 0; i < NUM_DISPLAYS; i++)
                r[CHAR_WIDTH*i +: CHAR_WIDTH] = m_buf[(m_idx + i) % m_len];
        return r;
    endfunction

    // Advance the model by one clock edge using the inputs the DUT just sampled.
    task automatic modelClock();
        logic [WIN_W-1:0] next_disp;
        int period;
        if (rst) begin
            m_mode = MODE_IDLE; m_len = 0; m_over = 0; m_idx = 0;
            m_pc = 0; m_step = 0; m_wcount = 0;
            m_disp = textWindow("      ");
            return;
        end
        next_disp = (m_mode == MODE_RUN || m_mode == MODE_HALT) ? modelWindow() : textWindow("      ");
        m_step = 0;
        case (m_mode)
            MODE_IDLE: begin
                if (wr_valid) begin
                    m_buf[0] = wr_data; m_wcount = 1; m_over = 0;
                    if (wr_last) m_len = 1;
                    else m_mode = MODE_LOAD;
                end else if (start && m_len != 0) begin
                    m_mode = MODE_RUN; m_idx = 0; m_pc = 0;
                end
            end
            MODE_LOAD: begin
                if (stop) begin
                    m_mode = MODE_IDLE;
                end else if (wr_valid) begin
                    if (m_wcount < MAX_LEN) begin
                        m_buf[m_wcount] = wr_data; m_wcount++;
                    end else begin
                        m_over = 1;
                    end
                    if (wr_last) begin
                        m_len = m_wcount; m_mode = MODE_IDLE;
                    end
                end
            end
            default: begin
                if (stop) begin
                    m_mode = MODE_IDLE; m_idx = 0;
                end else if (start) begin
                    m_mode = MODE_RUN; m_idx = 0; m_pc = 0;
                end else if (pause) begin
                    m_mode = MODE_HALT;
                end else if (m_mode == MODE_HALT) begin
                    m_mode = MODE_RUN;
                end else begin
                    period = TICK_DIV >> speed;
                    if (m_pc >= period - 1) begin
                        m_pc = 0; m_step = 1;
                        m_idx = scroll_dir ? (m_idx + m_len - 1) % m_len : (m_idx + 1) % m_len;
                    end else begin
                        m_pc++;
                    end
                end
            end
        endcase
        m_disp = next_disp;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        vectors++;
        assert (observed === expected) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic checkCycle();
        checkOutput("wr_ready", 64'(wr_ready), 64'(m_mode == MODE_IDLE || m_mode == MODE_LOAD));
        checkOutput("msg_len", 64'(msg_len), 64'(m_len));
        checkOutput("overflow", 64'(overflow), 64'(m_over));
        checkOutput("scroll_index", 64'(scroll_index), 64'(m_idx));
        checkOutput("step", 64'(step), 64'(m_step));
        checkOutput("busy", 64'(busy), 64'(m_mode == MODE_RUN || m_mode == MODE_HALT));
        checkOutput("display", 64'(display_chars), 64'(m_disp));
    endtask

    // One clock: edge, model update, then sample the DUT just after the edge.
    task automatic applyStimulus();
        @(posedge clk);
        modelClock();
        #1;
        checkCycle();
    endtask

    task automatic quietInputs();
        rst = 0; wr_valid = 0; wr_last = 0; wr_data = '0; start = 0; stop = 0;
    endtask

    task automatic pulseStart();
        start = 1; applyStimulus(); start = 0;
    endtask

    task automatic pulseStop();
        stop = 1; applyStimulus(); stop = 0;
    endtask

    task automatic loadQueue(input bit gaps);
        for (int i = 0; i < txq.size(); i++) begin
            if (gaps) repeat ($urandom_range(0, 2)) applyStimulus();
            wr_valid = 1; wr_data = txq[i]; wr_last = (i == txq.size() - 1);
            applyStimulus();
            wr_valid = 0; wr_last = 0;
        end
        txq.delete();
    endtask

    task automatic loadText(input string s, input bit gaps);
        txq.delete();
        for (int i = 0; i < s.len(); i++) txq.push_back(s[i]);
        loadQueue(gaps);
    endtask

    // Run until a step pulse is seen; running out of budget counts as a miscompare.
    task automatic waitStep(input int budget, output int cycles);
        cycles = 0;
        do begin
            applyStimulus();
            cycles++;
        end while (step !== 1'b1 && cycles < budget);
        checkOutput("step_wait", 64'(step), 64'd1);
    endtask

    initial begin
        int n;
        logic [IDX_W-1:0] held_idx;

        quietInputs();
        pause = 0; scroll_dir = 0; speed = 2'd2;
        rst = 1;
        applyStimulus();
        applyStimulus();
        rst = 0;
        $display("[TB] reset done");
        checkOutput("reset_len", 64'(msg_len), 64'd0);
        checkOutput("reset_display", 64'(display_chars), 64'(textWindow("      ")));
        checkOutput("reset_ready", 64'(wr_ready), 64'd1);

        // Forward scroll of an 11-character message at 4 cycles per step.
        loadText("HELLO 1234 ", 1);
        checkOutput("hello_len", 64'(msg_len), 64'd11);
        pulseStart();
        waitStep(10, n);
        checkOutput("hello_idx1", 64'(scroll_index), 64'd1);
        applyStimulus();
        checkOutput("hello_window", 64'(display_chars), 64'(textWindow("ELLO 1")));
        for (int s = 0; s < 10; s++) waitStep(10, n);
        checkOutput("hello_wrap", 64'(scroll_index), 64'd0);
        waitStep(10, n);
        checkOutput("hello_period", 64'(n), 64'd4);

        // Reverse scroll wraps from 0 to the last character.
        pulseStop();
        scroll_dir = 1;
        pulseStart();
        waitStep(10, n);
        checkOutput("rev_idx", 64'(scroll_index), 64'd10);
        applyStimulus();
        checkOutput("rev_window", 64'(display_chars), 64'(textWindow(" HELLO")));

        // Oversized load keeps the first 32 bytes and flags the drop.
        pulseStop();
        scroll_dir = 0;
        txq.delete();
        for (int i = 0; i < 35; i++) txq.push_back(char_t'($urandom_range(65, 90)));
        loadQueue(0);
        checkOutput("ovf_len", 64'(msg_len), 64'd32);
        checkOutput("ovf_flag", 64'(overflow), 64'd1);
        speed = 2'($urandom_range(0, 3));
        pulseStart();
        repeat (80) applyStimulus();

        // Two-character message repeats across the displays.
        pulseStop();
        speed = 2'd2;
        loadText("AB", 1);
        pulseStart();
        applyStimulus();
        checkOutput("ab_window", 64'(display_chars), 64'(textWindow("ABABAB")));
        waitStep(10, n);
        applyStimulus();
        checkOutput("ba_window", 64'(display_chars), 64'(textWindow("BABABA")));

        // Pause mid-count: index frozen, then one resume cycle plus the two remaining counts.
        applyStimulus();
        held_idx = scroll_index;
        pause = 1;
        repeat (10) applyStimulus();
        checkOutput("pause_idx", 64'(scroll_index), 64'(held_idx));
        pause = 0;
        waitStep(10, n);
        checkOutput("pause_resume", 64'(n), 64'd3);

        // start and stop together: stop wins.
        start = 1; stop = 1;
        applyStimulus();
        start = 0; stop = 0;
        checkOutput("startstop_busy", 64'(busy), 64'd0);
        applyStimulus();
        checkOutput("startstop_display", 64'(display_chars), 64'(textWindow("      ")));

        // Reset on the third byte of a load.
        wr_valid = 1; wr_data = "X"; applyStimulus();
        wr_data = "Y"; applyStimulus();
        wr_data = "Z"; rst = 1; applyStimulus();
        rst = 0; wr_valid = 0;
        checkOutput("rstload_len", 64'(msg_len), 64'd0);
        checkOutput("rstload_busy", 64'(busy), 64'd0);
        pulseStart();
        checkOutput("rstload_start_ignored", 64'(busy), 64'd0);

        // Fastest speed: 16 >> 3 gives a step every 2 cycles.
        speed = 2'd3;
        loadText("XYZ", 0);
        pulseStart();
        waitStep(20, n);
        waitStep(20, n);
        checkOutput("speed3_period", 64'(n), 64'd2);

        // Single-character message fills every display.
        pulseStop();
        loadText("Q", 0);
        checkOutput("single_len", 64'(msg_len), 64'd1);
        pulseStart();
        repeat (3) applyStimulus();
        checkOutput("single_window", 64'(display_chars), 64'(textWindow("QQQQQQ")));

        // Random mix of loads, control pulses, pause, direction and speed changes.
        $display("[TB] random phase");
        for (int c = 0; c < 1500; c++) begin
            quietInputs();
            wr_valid = ($urandom_range(0, 99) < 25);
            wr_data  = char_t'($urandom_range(32, 126));
            wr_last  = ($urandom_range(0, 5) == 0);
            start    = ($urandom_range(0, 39) == 0);
            stop     = ($urandom_range(0, 79) == 0);
            rst      = ($urandom_range(0, 399) == 0);
            if ($urandom_range(0, 15) == 0) pause = ~pause;
            if ($urandom_range(0, 49) == 0) speed = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 59) == 0) scroll_dir = ~scroll_dir;
            applyStimulus();
        end
        quietInputs();
        applyStimulus();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule

// File: doc/scroll_controller.md
Name: scroll_controller

Overview:
- Sequencer for the six-digit scrolling message display.
- Owns a loadable message buffer and the tick prescaler, and runs an IDLE/LOAD/SCROLL/PAUSED state machine.
- Produces the per-display character window that feeds the 7-segment decoders.
- Replaces the fixed message and external enable with a runtime-loaded message, start/stop/pause control and speed selection.

Parameters:
- MAX_LEN, 32: message buffer depth in characters.
- CHAR_WIDTH, 8: ASCII character width.
- NUM_DISPLAYS, 6: number of character outputs.
- TICK_DIV, 25_000_000: base clk cycles per scroll step at speed 0.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- wr_valid  in  1  load byte valid.
- wr_data  in  CHAR_WIDTH  load byte.
- wr_last  in  1  marks final byte of message.
- wr_ready  out  1  buffer accepts a byte.
- start  in  1  pulse: begin or restart scrolling.
- stop  in  1  pulse: return to IDLE.
- pause  in  1  level: freeze scrolling.
- scroll_dir  in  1  0 = index increments, 1 = index decrements.
- speed  in  2  step period = TICK_DIV >> speed.
- msg_len  out  $clog2(MAX_LEN+1)  stored length.
- overflow  out  1  sticky: bytes dropped on last load.
- scroll_index  out  $clog2(MAX_LEN)  current window start.
- step  out  1  one-cycle pulse on each index update.
- busy  out  1  high in SCROLL or PAUSED.
- display_chars  out  [NUM_DISPLAYS-1:0][CHAR_WIDTH-1:0]  window characters.

Behaviour:
- All state updates on posedge clk; rst is sampled synchronously.
- Reset values:
  - state=IDLE, msg_len=0, overflow=0, scroll_index=0, step=0, busy=0, prescaler=0.
  - Buffer contents are not reset.
  - wr_ready=1.
- wr_ready=1 in IDLE and LOAD, 0 otherwise. A byte transfers when wr_valid & wr_ready.
- IDLE:
  - Accepted byte: write to addr 0, wcount=1, clear overflow, go to LOAD.
  - If that byte also has wr_last: msg_len=1, stay in IDLE.
  - start with msg_len!=0: go to SCROLL with scroll_index=0 and prescaler=0. start with msg_len==0 is ignored.
- LOAD:
  - Accepted byte with wcount<MAX_LEN: write at wcount, wcount++.
  - Accepted byte with wcount==MAX_LEN: drop it, set overflow=1; wr_ready stays 1.
  - Accepted byte with wr_last: msg_len=min(wcount_after,MAX_LEN), go to IDLE.
  - start and pause are ignored. stop: go to IDLE, msg_len unchanged (partial load discarded).
- SCROLL:
  - Prescaler counts 0..(TICK_DIV>>speed)-1. On the terminal count: prescaler=0, step=1, and the index updates.
  - dir=0: index = (index==msg_len-1) ? 0 : index+1.
  - dir=1: index = (index==0) ? msg_len-1 : index-1.
  - pause=1: go to PAUSED.
- PAUSED: prescaler and index held, step=0. pause=0: return to SCROLL and resume the count from the held value.
- Priority in SCROLL/PAUSED, highest first: stop, start, pause, tick.
  - stop: go to IDLE, index=0.
  - start: index=0, prescaler=0, go to SCROLL even if pause=1 (pause takes effect the next cycle).
- A speed change mid-count: if prescaler ≥ new terminal count, the tick fires on the next cycle.
- Window (registered, one-cycle latency after an index update):
  - busy: display_chars[i] = buf[(scroll_index+i) mod msg_len]. msg_len<NUM_DISPLAYS repeats characters.
  - IDLE or LOAD: all outputs 0x20 (space).
- Modulo via compare-subtract only: index+i < 2*MAX_LEN is guaranteed. No divider.
- busy = (state==SCROLL || state==PAUSED).
- Reset mid-LOAD or mid-SCROLL: next cycle shows all reset values; display outputs spaces.

Decomposition:
- Package display_pkg holds:
  - CHAR_WIDTH.
  - ASCII_SPACE = 8'h20.
  - typedef enum logic [1:0] {IDLE, LOAD, SCROLL, PAUSED} scroll_state_t.
  - typedef char_t.
- Sub-module tick_prescaler:
  - Parameter TICK_DIV; inputs clk, rst, clear, hold, speed; output tick.
  - Instantiated once in scroll_controller.

Test Plan:
- TICK_DIV=4. Load "HELLO 1234 " (11 bytes, wr_last on the 11th), start.
  - Expect step every 4 cycles.
  - After the first step, display_chars[0..5] = "ELLO 1".
  - Index wraps 10→0 on the 11th step.
- Same message, dir=1, start.
  - First step: index 0→10, display_chars[0..5] = " HELLO".
- Load 35 bytes with MAX_LEN=32.
  - Expect msg_len=32, overflow=1, wr_ready never deasserts.
  - Bytes 33–35 absent from the window.
- Load "AB" (2 bytes), start.
  - Expect display_chars = "ABABAB", then "BABABA" after one step.
- While scrolling, assert pause for 10 cycles mid-count, then release.
  - Expect index frozen and no step pulses during pause.
  - Next step arrives after the remaining count.
  - start+stop in the same cycle → IDLE, all outputs 0x20.
- Assert rst during LOAD at byte 3.
  - Expect msg_len=0 and state IDLE next cycle.
  - start is then ignored (busy stays 0).
- speed=3 with TICK_DIV=16: expect step every 2 cycles.
